uart_tx_frame: RTL and testbench

Parametrised UART transmitter with a valid/ready byte input, runtime-programmable baud divisor, configurable data width, optional parity and 1 or 2 stop bits. It sits between an AXI-Stream-style byte source (FIFO or width converter) and the TX pin. It replaces the fixed 8N1 transmitter for links that need other frame formats or runtime baud changes.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_frame_if.sv | 9 +
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_frame.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, TX FSM state and data-width limits.
// The PARITY state exists only when UART_TX_FRAME_PARITY_EN is defined.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_FRAME_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Valid/ready byte stream feeding the UART transmitter.
interface uart_tx_frame_if #(parameter int DATA_BITS = 8);
  logic                 s_valid;
  logic [DATA_BITS-1:0] s_data;
  logic                 s_ready;

  modport master (output s_valid, s_data, input s_ready);
  modport slave  (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: load latches the reload value (div-1), and the
// counter then ticks once every reload+1 enabled clocks. Shared with the RX.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_reload;

  assign o_tick = i_en && (r_cnt == '0);

  // Count down while enabled; reload on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_reload <= '0;
    end else if (i_load) begin
      r_cnt    <= i_load_val;
      r_reload <= i_load_val;
    end else if (o_tick) begin
      r_cnt    <= r_reload;
    end else if (i_en) begin
      r_cnt    <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS data (LSB first), optional parity,
// 1 or 2 stop bits. Frame format and divisor are latched on acceptance.
// Parity support is compiled in with `define UART_TX_FRAME_PARITY_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_frame_if.slave   s,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int IDX_W = $clog2(MAX_DATA_BITS);

  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_width
    $error("uart_tx_frame: DATA_BITS must be within 5..9");
  end

  tx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 r_stop_idx, w_stop_idx_nxt;
  logic                 r_stop2;
  logic                 r_tx, r_busy, r_done;
  logic                 w_tx_nxt, w_done_nxt;
  logic                 w_accept, w_tick;
  logic [DIV_W-1:0]     w_div_m1;

`ifdef UART_TX_FRAME_PARITY_EN
  logic                     r_par_en, r_par_bit;
  logic [MAX_DATA_BITS-1:0] w_data_pad;

  // Widen the incoming byte for the shared parity helper.
  always_comb begin
    w_data_pad                 = '0;
    w_data_pad[DATA_BITS-1:0]  = s.s_data;
  end
`else
  logic w_unused_par;
  assign w_unused_par = ^cfg_parity;
`endif

  assign s.s_ready = (r_state == ST_IDLE);
  assign w_accept  = s.s_valid && s.s_ready;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign tx_done   = r_done;

  // Divisors 0 and 1 both mean one clock per bit.
  assign w_div_m1 = (cfg_div < DIV_W'(2)) ? '0 : cfg_div - DIV_W'(1);

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_load_val(w_div_m1),
    .i_en      (r_state != ST_IDLE),
    .o_tick    (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, shifter/counters and the next registered tx level.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_idx_nxt      = r_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_done_nxt     = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = ST_START;
        w_shift_nxt = s.s_data;
      end
      ST_START: if (w_tick) begin
        w_state_nxt    = ST_DATA;
        w_idx_nxt      = '0;
        w_stop_idx_nxt = 1'b0;
      end
      ST_DATA: if (w_tick) begin
        if (r_idx == IDX_W'(DATA_BITS-1)) begin
`ifdef UART_TX_FRAME_PARITY_EN
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
`else
          w_state_nxt = ST_STOP;
`endif
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_shift_nxt = r_shift >> 1;
        end
      end
`ifdef UART_TX_FRAME_PARITY_EN
      ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
`endif
      ST_STOP: if (w_tick) begin
        if (r_stop2 && !r_stop_idx) begin
          w_stop_idx_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_FRAME_PARITY_EN
      ST_PARITY: w_tx_nxt = r_par_bit;
`endif
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  // Datapath registers, registered outputs and frame config latched at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_FRAME_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_shift    <= w_shift_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done_nxt;
      if (w_accept) begin
        r_stop2   <= cfg_stop2;
`ifdef UART_TX_FRAME_PARITY_EN
        r_par_en  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
        r_par_bit <= calc_parity(w_data_pad, cfg_parity == PAR_ODD);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame (DATA_BITS=8). Parity frames are checked
// when UART_TX_FRAME_PARITY_EN is defined, otherwise cfg_parity must be ignored.
module tb_uart_tx_frame;

  localparam int DB = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] cfg_div;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic          tx, busy, tx_done;

  uart_tx_frame_if #(.DATA_BITS(DB)) sif ();

  uart_tx_frame #(.DATA_BITS(DB), .DIV_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (sif),
    .cfg_div   (cfg_div),
    .cfg_parity(cfg_parity),
    .cfg_stop2 (cfg_stop2),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic tx_log   [0:99];
  logic busy_log [0:99];
  logic done_log [0:99];
  logic rdy_log  [0:99];

  logic [15:0] ef;  // expected frame bits, index 0 = start bit
  int          en;  // expected frame length in bits

  // Hand-built expected frame: start, data LSB first, optional parity, stops.
  task automatic build(input logic [7:0] d, input bit has_par, input bit pbit, input bit stop2);
    ef = '1; en = 0;
    ef[en] = 1'b0; en++;
    for (int i = 0; i < 8; i++) begin ef[en] = d[i]; en++; end
    if (has_par) begin ef[en] = pbit; en++; end
    ef[en] = 1'b1; en++;
    if (stop2) begin ef[en] = 1'b1; en++; end
  endtask

  // Present one byte while idle; returns #1 after the acceptance edge E0.
  task automatic start(input logic [7:0] d, input logic [DW-1:0] div, input logic [1:0] par, input bit stop2);
    sif.s_data = d; cfg_div = div; cfg_parity = par; cfg_stop2 = stop2;
    sif.s_valid = 1'b1;
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
  endtask

  // Record outputs at E0+0..E0+ncyc; optionally drop s_valid / change cfg_div.
  task automatic capture(input int ncyc, input int drop_at, input int cdiv_at, input logic [DW-1:0] cdiv_val);
    for (int i = 0; i <= ncyc; i++) begin
      tx_log[i] = tx; busy_log[i] = busy; done_log[i] = tx_done; rdy_log[i] = sif.s_ready;
      if (i == drop_at) sif.s_valid = 1'b0;
      if (i == cdiv_at) cfg_div = cdiv_val;
      if (i < ncyc) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0;
    cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || sif.s_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_in: tx=%b busy=%b done=%b rdy=%b, want 1 0 0 1", tx, busy, tx_done, sif.s_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || sif.s_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_out: tx=%b busy=%b done=%b rdy=%b, want 1 0 0 1", tx, busy, tx_done, sif.s_ready);
    end
  endtask

  task automatic test_basic();
    build(8'h55, 0, 0, 0);
    start(8'h55, 16'd4, 2'b00, 0);
    capture(41, -1, -1, '0);
    for (int j = 0; j < 40; j++) begin
      nchk++;
      if (tx_log[j] !== ef[j/4] || busy_log[j] !== 1'b1 || done_log[j] !== 1'b0 || rdy_log[j] !== 1'b0) begin
        nerr++; $display("FAIL basic E0+%0d: tx=%b busy=%b done=%b rdy=%b, want tx=%b busy=1 done=0 rdy=0",
                         j, tx_log[j], busy_log[j], done_log[j], rdy_log[j], ef[j/4]);
      end
    end
    nchk++;
    if (tx_log[40] !== 1'b1 || done_log[40] !== 1'b1 || rdy_log[40] !== 1'b1 || busy_log[40] !== 1'b0) begin
      nerr++; $display("FAIL basic_end E0+40: tx=%b done=%b rdy=%b busy=%b, want 1 1 1 0",
                       tx_log[40], done_log[40], rdy_log[40], busy_log[40]);
    end
    nchk++;
    if (done_log[41] !== 1'b0) begin
      nerr++; $display("FAIL basic_pulse E0+41: done=%b, want 0", done_log[41]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f1, f2;
    int pulses;
    build(8'hA5, 0, 0, 0); f1 = ef;
    build(8'h3C, 0, 0, 0); f2 = ef;
    sif.s_data = 8'hA5; cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    sif.s_valid = 1'b1;
    @(posedge clk); #1;
    sif.s_data = 8'h3C;
    capture(82, 41, -1, '0);
    pulses = 0;
    for (int j = 0; j <= 82; j++) if (done_log[j] === 1'b1) pulses++;
    nchk++;
    if (pulses !== 2 || done_log[40] !== 1'b1 || done_log[81] !== 1'b1) begin
      nerr++; $display("FAIL b2b_done: pulses=%0d done40=%b done81=%b, want 2 1 1", pulses, done_log[40], done_log[81]);
    end
    nchk++;
    if (tx_log[40] !== 1'b1 || tx_log[41] !== 1'b0) begin
      nerr++; $display("FAIL b2b_gap: tx40=%b tx41=%b, want 1 0", tx_log[40], tx_log[41]);
    end
    for (int j = 0; j < 40; j++) begin
      nchk++;
      if (tx_log[j] !== f1[j/4] || tx_log[j+41] !== f2[j/4] || busy_log[j+41] !== 1'b1) begin
        nerr++; $display("FAIL b2b_bits k=%0d: tx1=%b tx2=%b busy2=%b, want %b %b 1",
                         j, tx_log[j], tx_log[j+41], busy_log[j+41], f1[j/4], f2[j/4]);
      end
    end
  endtask

  task automatic test_parity();
    bit has_par;
    int ncy;
`ifdef UART_TX_FRAME_PARITY_EN
    has_par = 1;
`else
    has_par = 0;
`endif
    for (int m = 0; m < 2; m++) begin
      // 0x07 has three ones: even parity bit 1, odd parity bit 0.
      build(8'h07, has_par, (m == 0), 0);
      ncy = en * 4;
      start(8'h07, 16'd4, (m == 0) ? 2'b01 : 2'b10, 0);
      capture(ncy + 1, -1, -1, '0);
      for (int j = 0; j < ncy; j++) begin
        nchk++;
        if (tx_log[j] !== ef[j/4] || busy_log[j] !== 1'b1 || done_log[j] !== 1'b0) begin
          nerr++; $display("FAIL parity m=%0d E0+%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                           m, j, tx_log[j], busy_log[j], done_log[j], ef[j/4]);
        end
      end
      nchk++;
      if (done_log[ncy] !== 1'b1 || rdy_log[ncy] !== 1'b1 || busy_log[ncy] !== 1'b0) begin
        nerr++; $display("FAIL parity_end m=%0d E0+%0d: done=%b rdy=%b busy=%b, want 1 1 0",
                         m, ncy, done_log[ncy], rdy_log[ncy], busy_log[ncy]);
      end
    end
  endtask

  task automatic test_stop2_div1();
    for (int m = 0; m < 2; m++) begin
      build(8'hFF, 0, 0, 1);
      start(8'hFF, (m == 0) ? 16'd1 : 16'd0, 2'b00, 1);
      capture(12, -1, -1, '0);
      for (int j = 0; j < 11; j++) begin
        nchk++;
        if (tx_log[j] !== ef[j] || busy_log[j] !== 1'b1 || done_log[j] !== 1'b0) begin
          nerr++; $display("FAIL stop2 div=%0d E0+%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                           1 - m, j, tx_log[j], busy_log[j], done_log[j], ef[j]);
        end
      end
      nchk++;
      if (done_log[11] !== 1'b1 || busy_log[11] !== 1'b0 || done_log[12] !== 1'b0) begin
        nerr++; $display("FAIL stop2_end div=%0d: done11=%b busy11=%b done12=%b, want 1 0 0",
                         1 - m, done_log[11], busy_log[11], done_log[12]);
      end
    end
  endtask

  task automatic test_cfg_change();
    build(8'h0F, 0, 0, 0);
    start(8'h0F, 16'd4, 2'b00, 0);
    capture(41, -1, 10, 16'd8);
    for (int j = 0; j < 40; j++) begin
      nchk++;
      if (tx_log[j] !== ef[j/4] || busy_log[j] !== 1'b1) begin
        nerr++; $display("FAIL cfg_cur E0+%0d: tx=%b busy=%b, want tx=%b busy=1", j, tx_log[j], busy_log[j], ef[j/4]);
      end
    end
    nchk++;
    if (done_log[40] !== 1'b1) begin
      nerr++; $display("FAIL cfg_cur_end: done40=%b, want 1", done_log[40]);
    end
    start(8'h0F, 16'd8, 2'b00, 0);
    capture(81, -1, -1, '0);
    for (int j = 0; j < 80; j++) begin
      nchk++;
      if (tx_log[j] !== ef[j/8] || busy_log[j] !== 1'b1 || done_log[j] !== 1'b0) begin
        nerr++; $display("FAIL cfg_next E0+%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                         j, tx_log[j], busy_log[j], done_log[j], ef[j/8]);
      end
    end
    nchk++;
    if (done_log[80] !== 1'b1 || busy_log[80] !== 1'b0) begin
      nerr++; $display("FAIL cfg_next_end: done80=%b busy80=%b, want 1 0", done_log[80], busy_log[80]);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    start(8'h00, 16'd4, 2'b00, 0);
    capture(13, -1, -1, '0);
    nchk++;
    if (tx_log[13] !== 1'b0 || busy_log[13] !== 1'b1) begin
      nerr++; $display("FAIL rst_pre E0+13: tx=%b busy=%b, want 0 1", tx_log[13], busy_log[13]);
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      nerr++; $display("FAIL rst_async: tx=%b busy=%b done=%b, want 1 0 0", tx, busy, tx_done);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0 || sif.s_ready !== 1'b1) bad++;
    end
    nchk++;
    if (bad !== 0) begin
      nerr++; $display("FAIL rst_idle: %0d bad idle cycles after release, want 0", bad);
    end
    build(8'h55, 0, 0, 0);
    start(8'h55, 16'd4, 2'b00, 0);
    capture(40, -1, -1, '0);
    for (int j = 0; j < 40; j++) begin
      nchk++;
      if (tx_log[j] !== ef[j/4] || done_log[j] !== 1'b0) begin
        nerr++; $display("FAIL rst_next E0+%0d: tx=%b done=%b, want tx=%b done=0", j, tx_log[j], done_log[j], ef[j/4]);
      end
    end
    nchk++;
    if (done_log[40] !== 1'b1 || tx_log[40] !== 1'b1) begin
      nerr++; $display("FAIL rst_next_end: done=%b tx=%b, want 1 1", done_log[40], tx_log[40]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_stop2_div1();
    test_cfg_change();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
